pf_req_sched: RTL and testbench
===============================

// Module: pf_req_sched
// PURPOSE
//  Prefetch request scheduler between the prefetch generator and the per-pipe cache request ports.
//  Accepts one prefetch op (laddr, delta, weight, sptbr) and expands it into up to MAX_DEGREE line requests.
//  Steers each request to the DC or L2 port class by weight, and to pipe 0/1 by line-address bit.
//  One-entry output slot per port; valid/retry handshake on every port.
// PARAMETERS
//  LADDR_W        39  logical address width
//  SPTBR_W        38  page-table base width
//  DELTA_W        8   signed stride, in cache lines
//  WEIGHT_W       4   confidence weight width
//  LINE_SHIFT     6   log2 line bytes; pipe select = addr[LINE_SHIFT]
//  PAGE_SHIFT     12  log2 page bytes; requests never cross a page
//  MAX_DEGREE     4   max requests per op
//  DC_WEIGHT_MIN  8   weight >= this -> DC ports, else L2 ports
// PORTS
//  clk                  in   1         clock
//  reset                in   1         async, active-high
//  pfgtopfe_op_valid    in   1         op offered
//  pfgtopfe_op_retry    out  1         op not accepted this cycle
//  pfgtopfe_op_d        in   DELTA_W   signed stride (lines)
//  pfgtopfe_op_w        in   WEIGHT_W  weight
//  pfgtopfe_op_laddr    in   LADDR_W   base address
//  pfgtopfe_op_sptbr    in   SPTBR_W   address space tag
//  pftodc_reqP_valid    out  1         P=0,1: DC request valid
//  pftodc_reqP_retry    in   1         P=0,1: DC port stall
//  pftodc_reqP_laddr    out  LADDR_W   P=0,1: line address, low LINE_SHIFT bits 0
//  pftodc_reqP_sptbr    out  SPTBR_W   P=0,1: sptbr of the originating op
//  pftol2_reqP_*        same set for the L2 ports (P=0,1)
//  pf_drop_cnt          out  16        ops dropped or truncated, saturating
// BEHAVIOUR
//  Handshake: transfer on any port when valid && !retry. Output valid/laddr/sptbr stay stable until transferred.
//  op_retry = (state != IDLE) | reset. Op is accepted in cycle T when valid && !retry.
//  Reset, async: state IDLE, all req valids 0, op_retry 1 while reset is high, pf_drop_cnt 0.
//  The base address, line-aligned base, delta, sptbr, class (w >= DC_WEIGHT_MIN) and k=1 latch at acceptance.
//  degree = min((w >> 2) + 1, MAX_DEGREE).
//  FSM states: IDLE, ISSUE.
//  IDLE -> ISSUE on acceptance. Exception: w==0 or d==0 drops the op, increments pf_drop_cnt and stays IDLE.
//  In ISSUE, candidate addr_k = base + k*(sext(d) << LINE_SHIFT), computed mod 2^LADDR_W.
//  The target slot is the selected class, pipe addr_k[LINE_SHIFT].
//  If addr_k[LADDR_W-1:PAGE_SHIFT] != base[LADDR_W-1:PAGE_SHIFT]:
//    - increment pf_drop_cnt and go to IDLE;
//    - no further requests from this op.
//  Otherwise the candidate loads its slot when the slot is empty or transfers this cycle.
//    - The slot valid is visible the next cycle, so the first request is valid at T+2.
//    - If the slot is full and stalled, hold k (no skip, no reorder).
//  After loading k == degree, go to IDLE, so op_retry drops the next cycle.
//  Throughput is 1 request per cycle when slots drain.
//  Requests from one op appear per port in increasing k order.
//  Non-target slots keep draining independently while ISSUE stalls.
//  pf_drop_cnt saturates at 16'hFFFF.
//  Reset mid-ISSUE abandons the op and clears all slots. Pending outputs are lost and are not counted.
//  Simultaneous slot transfer and reload in the same cycle is legal: the new value is presented the next cycle.
// TESTING
//  (LINE_SHIFT=6, PAGE_SHIFT=12, DC_WEIGHT_MIN=8, MAX_DEGREE=4, all retries 0 unless noted)
//  1 laddr=0x1000,d=1,w=12 -> DC pipe1 0x1040, pipe0 0x1080, pipe1 0x10C0, pipe0 0x1100.
//    First valid at T+2, one per cycle; op_retry high T+1..T+4.
//  2 laddr=0x2100,d=-2,w=4, pftol2_req0_retry=1 for 3 cycles
//    -> L2 pipe0 0x2080 held stable 3 cycles, then 0x2000.
//    No DC traffic; op_retry stays high until 0x2000 loads.
//  3 laddr=0x0F80,d=1,w=12 -> one DC request 0x0FC0 (pipe1); 0x1000 crosses the page -> op ends, pf_drop_cnt=1.
//  4 w=0 or d=0 ops, back to back -> accepted at 1 per cycle, no requests, pf_drop_cnt +1 each.
//    Force count 0xFFFE and drop 3 ops -> 0xFFFF.
//  5 Accept op from test 1 and assert reset at T+3 -> all valids 0 and op_retry 1 during reset.
//    After release, a new op issues normally from k=1.
//  6 Random ops with random retries vs a reference model.
//    Check per-port order, data stability under retry, no lost/duplicate requests, and that no request crosses its page.

Source files
------------

// File: rtl/pf_req_sched.sv
// Prefetch request scheduler: expands one prefetch op into up to MAX_DEGREE
// line requests and steers them to DC/L2 by weight and to pipe 0/1 by line bit.
module pf_req_sched #(
   parameter int LADDR_W       = 39,
   parameter int SPTBR_W       = 38,
   parameter int DELTA_W       = 8,
   parameter int WEIGHT_W      = 4,
   parameter int LINE_SHIFT    = 6,
   parameter int PAGE_SHIFT    = 12,
   parameter int MAX_DEGREE    = 4,
   parameter int DC_WEIGHT_MIN = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                pfgtopfe_op_valid,
   output logic                pfgtopfe_op_retry,
   input  logic [DELTA_W-1:0]  pfgtopfe_op_d,
   input  logic [WEIGHT_W-1:0] pfgtopfe_op_w,
   input  logic [LADDR_W-1:0]  pfgtopfe_op_laddr,
   input  logic [SPTBR_W-1:0]  pfgtopfe_op_sptbr,
   output logic                pftodc_req0_valid,
   input  logic                pftodc_req0_retry,
   output logic [LADDR_W-1:0]  pftodc_req0_laddr,
   output logic [SPTBR_W-1:0]  pftodc_req0_sptbr,
   output logic                pftodc_req1_valid,
   input  logic                pftodc_req1_retry,
   output logic [LADDR_W-1:0]  pftodc_req1_laddr,
   output logic [SPTBR_W-1:0]  pftodc_req1_sptbr,
   output logic                pftol2_req0_valid,
   input  logic                pftol2_req0_retry,
   output logic [LADDR_W-1:0]  pftol2_req0_laddr,
   output logic [SPTBR_W-1:0]  pftol2_req0_sptbr,
   output logic                pftol2_req1_valid,
   input  logic                pftol2_req1_retry,
   output logic [LADDR_W-1:0]  pftol2_req1_laddr,
   output logic [SPTBR_W-1:0]  pftol2_req1_sptbr,
   output logic [15:0]         pf_drop_cnt
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_ISSUE = 1'b1;
   localparam int DEG_W  = $clog2(MAX_DEGREE + 1);
   localparam int PAGE_W = LADDR_W - PAGE_SHIFT;
   localparam int EXT_W  = LADDR_W - DELTA_W - LINE_SHIFT;

   logic [0:0]          r_state;
   logic [LADDR_W-1:0]  r_addr;
   logic [LADDR_W-1:0]  r_stride;
   logic [PAGE_W-1:0]   r_page;
   logic [SPTBR_W-1:0]  r_sptbr;
   logic                r_is_dc;
   logic [DEG_W-1:0]    r_k;
   logic [DEG_W-1:0]    r_degree;
   logic [15:0]         r_drop_cnt;

   // Slot index = {is_dc, pipe}: 0 L2 pipe0, 1 L2 pipe1, 2 DC pipe0, 3 DC pipe1.
   logic [3:0]          r_slot_valid;
   logic [LADDR_W-1:0]  r_slot_laddr [4];
   logic [SPTBR_W-1:0]  r_slot_sptbr [4];

   logic                w_accept;
   logic                w_op_null;
   logic                w_cross;
   logic                w_slot_free;
   logic                w_issue_ok;
   logic                w_drop;
   logic [1:0]          w_target;
   logic [3:0]          w_slot_retry;
   logic [3:0]          w_xfer;
   logic [3:0]          w_load;
   logic [LADDR_W-1:0]  w_stride;
   logic [LADDR_W-1:0]  w_base_line;
   logic [WEIGHT_W:0]   w_deg_raw;
   logic [DEG_W-1:0]    w_degree;
   logic                w_unused_bits;

   assign pfgtopfe_op_retry = (r_state != ST_IDLE) | reset;
   assign w_accept    = pfgtopfe_op_valid & ~pfgtopfe_op_retry;
   assign w_op_null   = (pfgtopfe_op_w == '0) || (pfgtopfe_op_d == '0);
   assign w_stride    = {{EXT_W{pfgtopfe_op_d[DELTA_W-1]}}, pfgtopfe_op_d, {LINE_SHIFT{1'b0}}};
   assign w_base_line = {pfgtopfe_op_laddr[LADDR_W-1:LINE_SHIFT], {LINE_SHIFT{1'b0}}};
   assign w_unused_bits = ^pfgtopfe_op_laddr[LINE_SHIFT-1:0];
   assign w_deg_raw   = ({1'b0, pfgtopfe_op_w} >> 2) + (WEIGHT_W+1)'(1);
   assign w_degree    = (w_deg_raw >= (WEIGHT_W+1)'(MAX_DEGREE)) ? DEG_W'(MAX_DEGREE)
                                                                 : w_deg_raw[DEG_W-1:0];

   assign w_slot_retry = {pftodc_req1_retry, pftodc_req0_retry,
                          pftol2_req1_retry, pftol2_req0_retry};
   assign w_target     = {r_is_dc, r_addr[LINE_SHIFT]};
   assign w_cross      = r_addr[LADDR_W-1:PAGE_SHIFT] != r_page;
   // A slot that hands off this cycle can take the next candidate immediately.
   assign w_slot_free  = ~r_slot_valid[w_target] | w_xfer[w_target];
   assign w_issue_ok   = (r_state == ST_ISSUE) & ~w_cross & w_slot_free;
   assign w_drop       = (w_accept & w_op_null) | ((r_state == ST_ISSUE) & w_cross);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_slot_ctl
         assign w_xfer[gi] = r_slot_valid[gi] & ~w_slot_retry[gi];
         assign w_load[gi] = w_issue_ok & (w_target == 2'(gi));
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_slot_valid <= '0;
         for (int i = 0; i < 4; i++) begin
            r_slot_laddr[i] <= '0;
            r_slot_sptbr[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (w_load[i]) begin
               r_slot_valid[i] <= 1'b1;
               r_slot_laddr[i] <= r_addr;
               r_slot_sptbr[i] <= r_sptbr;
            end else if (w_xfer[i]) begin
               r_slot_valid[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_addr     <= '0;
         r_stride   <= '0;
         r_page     <= '0;
         r_sptbr    <= '0;
         r_is_dc    <= 1'b0;
         r_k        <= '0;
         r_degree   <= '0;
         r_drop_cnt <= '0;
      end else begin
         if (w_drop && (r_drop_cnt != 16'hFFFF))
            r_drop_cnt <= r_drop_cnt + 16'd1;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  // r_addr always holds the k-th candidate, starting at k=1.
                  r_addr   <= w_base_line + w_stride;
                  r_stride <= w_stride;
                  r_page   <= w_base_line[LADDR_W-1:PAGE_SHIFT];
                  r_sptbr  <= pfgtopfe_op_sptbr;
                  r_is_dc  <= pfgtopfe_op_w >= WEIGHT_W'(DC_WEIGHT_MIN);
                  r_k      <= DEG_W'(1);
                  r_degree <= w_degree;
                  if (!w_op_null)
                     r_state <= ST_ISSUE;
               end
            end
            default: begin
               if (w_cross) begin
                  r_state <= ST_IDLE;
               end else if (w_issue_ok) begin
                  if (r_k == r_degree) begin
                     r_state <= ST_IDLE;
                  end else begin
                     r_k    <= r_k + DEG_W'(1);
                     r_addr <= r_addr + r_stride;
                  end
               end
            end
         endcase
      end
   end

   assign pftol2_req0_valid = r_slot_valid[0];
   assign pftol2_req0_laddr = r_slot_laddr[0];
   assign pftol2_req0_sptbr = r_slot_sptbr[0];
   assign pftol2_req1_valid = r_slot_valid[1];
   assign pftol2_req1_laddr = r_slot_laddr[1];
   assign pftol2_req1_sptbr = r_slot_sptbr[1];
   assign pftodc_req0_valid = r_slot_valid[2];
   assign pftodc_req0_laddr = r_slot_laddr[2];
   assign pftodc_req0_sptbr = r_slot_sptbr[2];
   assign pftodc_req1_valid = r_slot_valid[3];
   assign pftodc_req1_laddr = r_slot_laddr[3];
   assign pftodc_req1_sptbr = r_slot_sptbr[3];
   assign pf_drop_cnt       = r_drop_cnt;

endmodule

// File: tb/tb_pf_req_sched.sv
// Scoreboard bench for pf_req_sched: directed vectors push expected requests,
// a negedge monitor pops and compares them per port as they transfer.
module tb_pf_req_sched;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        op_valid = 1'b0;
   logic        op_retry;
   logic [7:0]  op_d = '0;
   logic [3:0]  op_w = '0;
   logic [38:0] op_laddr = '0;
   logic [37:0] op_sptbr = '0;
   logic        dc_v0, dc_v1, l2_v0, l2_v1;
   logic        dc_r0, dc_r1, l2_r0, l2_r1;
   logic [38:0] dc_a0, dc_a1, l2_a0, l2_a1;
   logic [37:0] dc_s0, dc_s1, l2_s0, l2_s1;
   logic [15:0] drop_cnt;

   bit          rnd_en = 1'b0;
   bit          hold_l2r0 = 1'b0;
   logic [3:0]  rnd_r = '0;

   typedef struct packed {
      logic [1:0]  port;
      logic [38:0] a;
      logic [37:0] s;
   } exp_t;
   exp_t sb[$];
   int total = 0;
   int bad = 0;
   int exp_drop = 0;

   logic [3:0]  mv, mr;
   logic [38:0] ma [4];
   logic [37:0] ms [4];
   logic [3:0]  pv = '0, pr = '0;
   logic [38:0] pa [4];
   logic [37:0] ps [4];

   always #5 clk = ~clk;

   assign l2_r0 = rnd_en ? rnd_r[0] : hold_l2r0;
   assign l2_r1 = rnd_en ? rnd_r[1] : 1'b0;
   assign dc_r0 = rnd_en ? rnd_r[2] : 1'b0;
   assign dc_r1 = rnd_en ? rnd_r[3] : 1'b0;
   assign mv = {dc_v1, dc_v0, l2_v1, l2_v0};
   assign mr = {dc_r1, dc_r0, l2_r1, l2_r0};
   assign ma[0] = l2_a0; assign ma[1] = l2_a1; assign ma[2] = dc_a0; assign ma[3] = dc_a1;
   assign ms[0] = l2_s0; assign ms[1] = l2_s1; assign ms[2] = dc_s0; assign ms[3] = dc_s1;

   pf_req_sched dut (
      .clk(clk), .reset(reset),
      .pfgtopfe_op_valid(op_valid), .pfgtopfe_op_retry(op_retry),
      .pfgtopfe_op_d(op_d), .pfgtopfe_op_w(op_w),
      .pfgtopfe_op_laddr(op_laddr), .pfgtopfe_op_sptbr(op_sptbr),
      .pftodc_req0_valid(dc_v0), .pftodc_req0_retry(dc_r0),
      .pftodc_req0_laddr(dc_a0), .pftodc_req0_sptbr(dc_s0),
      .pftodc_req1_valid(dc_v1), .pftodc_req1_retry(dc_r1),
      .pftodc_req1_laddr(dc_a1), .pftodc_req1_sptbr(dc_s1),
      .pftol2_req0_valid(l2_v0), .pftol2_req0_retry(l2_r0),
      .pftol2_req0_laddr(l2_a0), .pftol2_req0_sptbr(l2_s0),
      .pftol2_req1_valid(l2_v1), .pftol2_req1_retry(l2_r1),
      .pftol2_req1_laddr(l2_a1), .pftol2_req1_sptbr(l2_s1),
      .pf_drop_cnt(drop_cnt)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic push(input int port, input logic [38:0] a, input logic [37:0] s);
      exp_t e;
      e.port = 2'(port);
      e.a = a;
      e.s = s;
      sb.push_back(e);
   endtask

   task automatic bump_drop();
      if (exp_drop < 65535) exp_drop++;
   endtask

   // Reference expansion of one op into its expected per-port requests.
   task automatic model_op(input logic [38:0] base, input logic [7:0] d,
                           input logic [3:0] w, input logic [37:0] s);
      logic [38:0] ab;
      logic [38:0] a;
      logic [63:0] t;
      longint      st;
      int          deg;
      bit          dc;
      if (w == 0 || d == 0) begin
         bump_drop();
         return;
      end
      deg = (int'(w) >> 2) + 1;
      if (deg > 4) deg = 4;
      dc = (w >= 4'd8);
      ab = {base[38:6], 6'b0};
      st = longint'($signed(d)) * 64;
      for (int k = 1; k <= deg; k++) begin
         t = 64'(ab) + 64'(longint'(k) * st);
         a = t[38:0];
         if (a[38:12] != ab[38:12]) begin
            bump_drop();
            break;
         end
         push((dc ? 2 : 0) + int'(a[6]), a, s);
      end
   endtask

   task automatic send_op(input logic [38:0] la, input logic [7:0] d,
                          input logic [3:0] w, input logic [37:0] s);
      bit ok;
      ok = 1'b0;
      op_laddr = la; op_d = d; op_w = w; op_sptbr = s; op_valid = 1'b1;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         if (!op_retry) ok = 1'b1;
         @(posedge clk); #1;
      end
      op_valid = 1'b0;
      $display("op laddr=%0h d=%0d w=%0d accepted=%0d", la, $signed(d), w, ok);
      if (!ok) chk("op_accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 3000 && !ok; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && mv == 4'b0 && !op_retry) ok = 1'b1;
      end
      @(posedge clk); #1;
      if (!ok) chk("idle_timeout", 64'd0, 64'd1);
   endtask

   always @(posedge clk) begin
      #1;
      rnd_r = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
   end

   // Monitor: data stability under retry, then in-order pop on each transfer.
   always @(negedge clk) begin
      if (reset) begin
         pv = '0;
      end else begin
         for (int p = 0; p < 4; p++) begin
            if (pv[p] && pr[p]) begin
               chk($sformatf("hold_valid_p%0d", p), 64'(mv[p]), 64'd1);
               chk($sformatf("hold_laddr_p%0d", p), 64'(ma[p]), 64'(pa[p]));
               chk($sformatf("hold_sptbr_p%0d", p), 64'(ms[p]), 64'(ps[p]));
            end
            if (mv[p] && !mr[p]) begin
               int idx;
               idx = -1;
               foreach (sb[i]) if (idx < 0 && sb[i].port == 2'(p)) idx = i;
               if (idx < 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_req_p%0d actual=%0h required=none", p, ma[p]);
               end else begin
                  $display("req port=%0d laddr=%0h sptbr=%0h", p, ma[p], ms[p]);
                  chk($sformatf("req_laddr_p%0d", p), 64'(ma[p]), 64'(sb[idx].a));
                  chk($sformatf("req_sptbr_p%0d", p), 64'(ms[p]), 64'(sb[idx].s));
                  sb.delete(idx);
               end
            end
         end
         pv = mv;
         pr = mr;
         for (int p = 0; p < 4; p++) begin
            pa[p] = ma[p];
            ps[p] = ms[p];
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valids", 64'(mv), 64'd0);
      chk("rst_op_retry", 64'(op_retry), 64'd1);
      chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // 1: DC, degree 4, alternating pipes, one request per cycle
      push(3, 39'h1040, 38'h123); push(2, 39'h1080, 38'h123);
      push(3, 39'h10C0, 38'h123); push(2, 39'h1100, 38'h123);
      send_op(39'h1000, 8'd1, 4'd12, 38'h123);
      @(negedge clk);
      chk("t1_retry_T1", 64'(op_retry), 64'd1);
      chk("t1_no_valid_T1", 64'(mv), 64'd0);
      @(negedge clk);
      chk("t1_retry_T2", 64'(op_retry), 64'd1);
      chk("t1_dc1_valid_T2", 64'(dc_v1), 64'd1);
      @(negedge clk);
      chk("t1_retry_T3", 64'(op_retry), 64'd1);
      @(negedge clk);
      chk("t1_retry_T4", 64'(op_retry), 64'd1);
      @(negedge clk);
      chk("t1_retry_T5", 64'(op_retry), 64'd0);
      wait_idle();

      // 2: L2 pipe0 stalled for 3 cycles, negative stride
      push(0, 39'h2080, 38'h2AA); push(0, 39'h2000, 38'h2AA);
      hold_l2r0 = 1'b1;
      send_op(39'h2100, 8'hFE, 4'd4, 38'h2AA);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t2_stall_valid", 64'(l2_v0), 64'd1);
         chk("t2_stall_laddr", 64'(l2_a0), 64'h2080);
      end
      @(posedge clk); #1;
      hold_l2r0 = 1'b0;
      @(negedge clk);
      chk("t2_retry_while_stalled", 64'(op_retry), 64'd1);
      @(negedge clk);
      chk("t2_retry_after_load", 64'(op_retry), 64'd0);
      chk("t2_second_laddr", 64'(l2_a0), 64'h2000);
      wait_idle();

      // 3: page crossing ends the op after one request
      push(3, 39'h0FC0, 38'h3);
      send_op(39'h0F80, 8'd1, 4'd12, 38'h3);
      wait_idle();
      chk("t3_drop_cnt", 64'(drop_cnt), 64'd1);

      // 4: null ops back to back, accepted one per cycle
      op_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         op_w = (i % 2 == 1) ? 4'd0 : 4'd5;
         op_d = (i % 2 == 1) ? 8'd3 : 8'd0;
         op_laddr = 39'h3000;
         @(negedge clk);
         chk("t4_null_accept", 64'(op_retry), 64'd0);
         @(posedge clk); #1;
      end
      op_valid = 1'b0;
      $display("op null x4 issued");
      wait_idle();
      chk("t4_drop_cnt", 64'(drop_cnt), 64'd5);

      // 5: reset during ISSUE abandons the op
      push(3, 39'h1040, 38'h55);
      send_op(39'h1000, 8'd1, 4'd12, 38'h55);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      chk("t5_rst_valids", 64'(mv), 64'd0);
      chk("t5_rst_retry", 64'(op_retry), 64'd1);
      chk("t5_sb_drained", 64'(sb.size()), 64'd0);
      sb.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      exp_drop = 0;
      chk("t5_drop_cleared", 64'(drop_cnt), 64'd0);
      push(3, 39'h5040, 38'h66); push(2, 39'h5080, 38'h66); push(3, 39'h50C0, 38'h66);
      send_op(39'h5000, 8'd1, 4'd8, 38'h66);
      wait_idle();

      // 6: random ops and retries against the reference expansion
      rnd_en = 1'b1;
      for (int n = 0; n < 30; n++) begin
         logic [38:0] la;
         logic [7:0]  d;
         logic [3:0]  w;
         logic [37:0] s;
         la = {7'($urandom), $urandom};
         d = 8'($urandom_range(0, 16) - 8);
         w = 4'($urandom_range(0, 15));
         s = {6'($urandom), $urandom};
         model_op(la, d, w, s);
         send_op(la, d, w, s);
      end
      repeat (20) @(posedge clk);
      #1;
      rnd_en = 1'b0;
      wait_idle();
      chk("t6_drop_cnt", 64'(drop_cnt), 64'(exp_drop));

      // 4b: saturation of the drop counter
      op_w = 4'd0; op_d = 8'd1; op_laddr = 39'h0;
      op_valid = 1'b1;
      repeat (16'hFFFE - exp_drop) @(posedge clk);
      #1;
      op_valid = 1'b0;
      $display("op null burst to count fffe");
      @(negedge clk);
      chk("sat_fffe", 64'(drop_cnt), 64'hFFFE);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         op_valid = 1'b1;
         @(posedge clk); #1;
         op_valid = 1'b0;
         $display("op null drop %0d", i);
         @(negedge clk);
         chk("sat_ffff", 64'(drop_cnt), 64'hFFFF);
      end

      chk("sb_leftover", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
